// File: rtl/bandit_arbiter_if.sv
// ============================================================================
// Module   : bandit_arbiter_if
// Brief    : Client-side and bandit-side handshake bundle for bandit_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface bandit_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    // Client side
    logic [N-1:0]   client_action_ready;
    logic [N-1:0]   client_action_valid;
    logic [W-1:0]   client_action_data;
    logic [N-1:0]   client_reward_valid;
    logic [N*W-1:0] client_reward_data;
    logic [N-1:0]   client_reward_ready;

    // Bandit side
    logic           action_valid;
    logic [W-1:0]   action_data;
    logic           action_ready;
    logic           reward_valid;
    logic [W-1:0]   reward_data;
    logic           reward_ready;

    // Arbiter view
    modport slave (
        input  client_action_ready, client_reward_valid, client_reward_data,
        input  action_valid, action_data, reward_ready,
        output client_action_valid, client_action_data, client_reward_ready,
        output action_ready, reward_valid, reward_data
    );

    // Environment view (clients plus bandit)
    modport master (
        output client_action_ready, client_reward_valid, client_reward_data,
        output action_valid, action_data, reward_ready,
        input  client_action_valid, client_action_data, client_reward_ready,
        input  action_ready, reward_valid, reward_data
    );
endinterface

`default_nettype wire

// File: rtl/bandit_arbiter.sv
// ============================================================================
// Module   : bandit_arbiter
// Brief    : Round-robin arbiter serialising client action/reward exchanges
//            with a single bandit engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bandit_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  wire logic                 clock,
    input  wire logic                 reset,
    input  wire logic [N-1:0]         enable,
    output logic [$clog2(N)-1:0]      grant,
    output logic                      busy,
    output logic [15:0]               count,
    bandit_arbiter_if.slave           bus
);

    localparam int GW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTION = 2'd1,
        S_REWARD = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_last;
    logic [15:0]     r_count;

    logic [N-1:0]    w_req;
    logic [GW-1:0]   w_pick;
    logic            w_found;
    int              w_idx;
    logic            w_reward_hs;

    assign w_req = bus.client_action_ready & enable;

    // Round-robin search starting just after the last-served client
    always_comb begin
        w_pick  = r_last;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= N; k++) begin
            w_idx = (int'(r_last) + k) % N;
            if (!w_found && w_req[w_idx]) begin
                w_pick  = GW'(w_idx);
                w_found = 1'b1;
            end
        end
    end

    assign w_reward_hs = (r_state == S_REWARD) && bus.reward_valid && bus.reward_ready;

    always_comb begin
        w_next_state            = r_state;
        bus.action_ready        = 1'b0;
        bus.client_action_valid = '0;
        bus.reward_valid        = 1'b0;
        bus.reward_data         = '0;
        bus.client_reward_ready = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next_state = S_ACTION;
                end
            end
            S_ACTION: begin
                bus.action_ready                 = bus.client_action_ready[r_grant];
                bus.client_action_valid[r_grant] = bus.action_valid;
                if (bus.action_valid && bus.client_action_ready[r_grant]) begin
                    w_next_state = S_REWARD;
                end
            end
            S_REWARD: begin
                bus.reward_valid                 = bus.client_reward_valid[r_grant];
                bus.reward_data                  = bus.client_reward_data[int'(r_grant)*W +: W];
                bus.client_reward_ready[r_grant] = bus.reward_ready;
                if (w_reward_hs) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_last  <= GW'(N - 1);
            r_grant <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && w_found) begin
                r_grant <= w_pick;
            end
            if (w_reward_hs) begin
                r_last  <= r_grant;
                r_count <= r_count + 16'd1;
            end
        end
    end

    // Action bus is broadcast; clients qualify it with their valid bit
    assign bus.client_action_data = bus.action_data;
    assign grant = r_grant;
    assign busy  = (r_state != S_IDLE);
    assign count = r_count;

endmodule

`default_nettype wire
